// File: rtl/async_queue_sink.sv
// async_queue_sink: sink-clock-domain read side of an asynchronous crossing queue.
//
// This block brings the source-domain Gray write pointer into the sink clock
// through a chain of plain flops. It then reads entries from the storage, which
// the source side owns, and presents each entry on a registered ready/valid
// dequeue port. The Gray read pointer goes back to the source side as a
// registered value.
//
// While the synchronized source_valid is low, the crossing is held in reset.
//
// Optional build macro: ASYNC_QUEUE_SINK_PTR_CHECK_EN
//   When defined, a sticky ptr_err flags any synchronized write-pointer step
//   that is not a single Gray increment. When undefined, ptr_err is tied low.
module async_queue_sink #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SYNC  = 3,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [AW:0]      async_widx,
    input  logic             source_valid,
    output logic [AW:0]      async_ridx,
    output logic [AW-1:0]    mem_index,
    input  logic [WIDTH-1:0] mem_data,
    output logic             deq_valid,
    input  logic             deq_ready,
    output logic [WIDTH-1:0] deq_bits,
    output logic             ptr_err
);

    logic [AW:0]      ridx_bin_q, ridx_bin_d;
    logic [AW:0]      async_ridx_q, async_ridx_d;
    logic [AW:0]      widx_sync_q [SYNC];
    logic [AW:0]      widx_sync_d [SYNC];
    logic             deq_valid_q, deq_valid_d;
    logic [WIDTH-1:0] deq_bits_q, deq_bits_d;

    logic [AW:0]      widx_s;
    logic [AW:0]      ridx_gray;
    logic             empty;
    logic             take;

    assign widx_s     = widx_sync_q[SYNC-1];
    assign ridx_gray  = ridx_bin_q ^ (ridx_bin_q >> 1);
    assign empty      = (ridx_gray == widx_s);
    assign take       = !empty && (!deq_valid_q || deq_ready);

    assign async_ridx = async_ridx_q;
    assign mem_index  = ridx_bin_q[AW-1:0];
    assign deq_valid  = deq_valid_q;
    assign deq_bits   = deq_bits_q;

    // Next-state logic: pointer synchronizer shift, read pointer, and output register.
    always_comb begin
        ridx_bin_d   = ridx_bin_q;
        async_ridx_d = async_ridx_q;
        deq_valid_d  = deq_valid_q;
        deq_bits_d   = deq_bits_q;

        widx_sync_d[0] = async_widx;
        for (int unsigned i = 1; i < SYNC; i++) begin
            widx_sync_d[i] = widx_sync_q[i-1];
        end

        if (!source_valid) begin
            // Source is in reset: drop the held entry and restart from index 0.
            // deq_bits is deliberately left untouched.
            ridx_bin_d   = '0;
            async_ridx_d = '0;
            deq_valid_d  = 1'b0;
            for (int unsigned i = 0; i < SYNC; i++) begin
                widx_sync_d[i] = '0;
            end
        end else if (take) begin
            deq_bits_d   = mem_data;
            deq_valid_d  = 1'b1;
            ridx_bin_d   = ridx_bin_q + 1'b1;
            async_ridx_d = ridx_bin_d ^ (ridx_bin_d >> 1);
        end else if (deq_valid_q && deq_ready) begin
            deq_valid_d  = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            ridx_bin_q   <= '0;
            async_ridx_q <= '0;
            deq_valid_q  <= 1'b0;
            deq_bits_q   <= '0;
            for (int unsigned i = 0; i < SYNC; i++) begin
                widx_sync_q[i] <= '0;
            end
        end else begin
            ridx_bin_q   <= ridx_bin_d;
            async_ridx_q <= async_ridx_d;
            deq_valid_q  <= deq_valid_d;
            deq_bits_q   <= deq_bits_d;
            for (int unsigned i = 0; i < SYNC; i++) begin
                widx_sync_q[i] <= widx_sync_d[i];
            end
        end
    end

`ifdef ASYNC_QUEUE_SINK_PTR_CHECK_EN
    logic [AW:0] widx_prev_q, widx_prev_d;
    logic        ptr_err_q, ptr_err_d;
    logic [AW:0] widx_step;
    logic [AW:0] prev_bin_inc;

    function automatic logic [AW:0] gray_to_bin(input logic [AW:0] g);
        logic [AW:0] b;
        for (int unsigned i = 0; i <= AW; i++) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

    assign widx_step    = widx_s ^ widx_prev_q;
    assign prev_bin_inc = gray_to_bin(widx_prev_q) + 1'b1;

    // Pointer integrity: each observed step must be exactly one Gray increment.
    always_comb begin
        widx_prev_d = widx_s;
        ptr_err_d   = ptr_err_q;
        if (widx_step != '0) begin
            if ((widx_step & (widx_step - 1'b1)) != '0) begin
                ptr_err_d = 1'b1;
            end
            if (gray_to_bin(widx_s) != prev_bin_inc) begin
                ptr_err_d = 1'b1;
            end
        end
        if (!source_valid) begin
            widx_prev_d = '0;
            ptr_err_d   = 1'b0;
        end
    end

    // Integrity check registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            widx_prev_q <= '0;
            ptr_err_q   <= 1'b0;
        end else begin
            widx_prev_q <= widx_prev_d;
            ptr_err_q   <= ptr_err_d;
        end
    end

    assign ptr_err = ptr_err_q;
`else
    assign ptr_err = 1'b0;
`endif

endmodule

// File: tb/tb_async_queue_sink.sv
// Testbench for async_queue_sink.
// A behavioural source model writes the storage and the Gray write pointer.
// A monitor compares the dequeue stream against a FIFO of the written data.
module tb_async_queue_sink;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned AW    = 3;
`ifdef ASYNC_QUEUE_SINK_PTR_CHECK_EN
    localparam bit PTR_CHK = 1'b1;
`else
    localparam bit PTR_CHK = 1'b0;
`endif

    logic             clock = 1'b0;
    logic             reset;
    logic [AW:0]      async_widx;
    logic             source_valid;
    logic [AW:0]      async_ridx;
    logic [AW-1:0]    mem_index;
    logic [WIDTH-1:0] mem_data;
    logic             deq_valid;
    logic             deq_ready;
    logic [WIDTH-1:0] deq_bits;
    logic             ptr_err;

    logic [WIDTH-1:0] mem [DEPTH];
    assign mem_data = mem[mem_index];

    async_queue_sink #(.DEPTH(DEPTH), .WIDTH(WIDTH), .SYNC(SYNC)) dut (
        .clock(clock), .reset(reset), .async_widx(async_widx),
        .source_valid(source_valid), .async_ridx(async_ridx),
        .mem_index(mem_index), .mem_data(mem_data), .deq_valid(deq_valid),
        .deq_ready(deq_ready), .deq_bits(deq_bits), .ptr_err(ptr_err)
    );

    always #5 clock = ~clock;

    int unsigned      checks = 0;
    int unsigned      failures = 0;
    logic [WIDTH-1:0] exp_q [$];
    int unsigned      wr_cnt = 0;
    int unsigned      popped = 0;
    bit               mon_en = 1'b0;
    bit               hold_pend = 1'b0;
    logic [WIDTH-1:0] held_bits;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW:0] to_gray(input int unsigned v);
        logic [AW:0] b;
        b = v[AW:0];
        return b ^ (b >> 1);
    endfunction

    function automatic logic [AW:0] from_gray(input logic [AW:0] g);
        logic [AW:0] b;
        b[AW] = g[AW];
        for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic bit can_push();
        int unsigned used;
        used = (wr_cnt - int'(from_gray(async_ridx))) & 32'hF;
        return used < DEPTH;
    endfunction

    task automatic push(input logic [WIDTH-1:0] data);
        mem[wr_cnt % DEPTH] = data;
        exp_q.push_back(data);
        wr_cnt++;
        async_widx = to_gray(wr_cnt);
    endtask

    task automatic model_clear();
        wr_cnt = 0;
        popped = 0;
        hold_pend = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        mon_en       = 1'b0;
        reset        = 1'b1;
        async_widx   = '0;
        source_valid = 1'b1;
        deq_ready    = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        model_clear();
    endtask

    task automatic drain(input int unsigned budget);
        int unsigned n = 0;
        deq_ready = 1'b1;
        while ((exp_q.size() != 0 || deq_valid) && n < budget) begin
            tick();
            n++;
        end
        check_eq("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: handshakes, holding rule, read pointer and fill bound.
    always @(negedge clock) begin
        if (mon_en) begin
            logic [WIDTH-1:0] e;
            int unsigned taken;
            int unsigned ahead;
            taken = popped + (deq_valid ? 1 : 0);
            check_eq("async_ridx", async_ridx, to_gray(taken));
            check_eq("mem_index", mem_index, 64'(taken % DEPTH));
            check_eq("ptr_err_quiet", ptr_err, 1'b0);
            ahead = (int'(from_gray(async_widx)) - int'(from_gray(async_ridx))) & 32'hF;
            check_eq("ahead_bound", 64'(ahead <= DEPTH), 64'd1);
            if (hold_pend) begin
                check_eq("hold_valid", deq_valid, 1'b1);
                check_eq("hold_bits", deq_bits, held_bits);
            end
            hold_pend = deq_valid && !deq_ready;
            held_bits = deq_bits;
            if (deq_valid && deq_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("spurious_valid", deq_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("deq_bits", deq_bits, e);
                    popped++;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] saved;
        int unsigned      pushed;
        int unsigned      guard;

        // Reset values
        do_reset();
        reset = 1'b1;
        tick();
        check_eq("rst_deq_valid", deq_valid, 1'b0);
        check_eq("rst_deq_bits", deq_bits, '0);
        check_eq("rst_async_ridx", async_ridx, '0);
        check_eq("rst_ptr_err", ptr_err, 1'b0);
        reset = 1'b0;
        mon_en = 1'b1;
        repeat (10) tick();
        check_eq("idle_deq_valid", deq_valid, 1'b0);
        check_eq("idle_async_ridx", async_ridx, '0);
        check_eq("idle_mem_index", mem_index, '0);

        // First entry latency
        deq_ready = 1'b1;
        push(32'hA5A5_0001);
        repeat (3) tick();
        check_eq("lat_early", deq_valid, 1'b0);
        tick();
        check_eq("lat_valid", deq_valid, 1'b1);
        check_eq("lat_bits", deq_bits, 32'hA5A5_0001);
        check_eq("lat_ridx", async_ridx, 4'b0001);
        tick();
        check_eq("lat_drop", deq_valid, 1'b0);

        // Fill all DEPTH entries with the consumer stalled, then stream them out
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            push($urandom);
            tick();
        end
        check_eq("full_widx", async_widx, 4'b1100);
        repeat (10) tick();
        check_eq("full_hold_valid", deq_valid, 1'b1);
        check_eq("full_hold_ridx", async_ridx, 4'b0001);
        deq_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check_eq("stream_valid", deq_valid, 1'b1);
            tick();
        end
        check_eq("stream_end", deq_valid, 1'b0);
        check_eq("stream_ridx", async_ridx, 4'b1100);

        // Random push/pop stream of 20 entries across two wraps
        do_reset();
        mon_en = 1'b1;
        pushed = 0;
        guard = 0;
        while (pushed < 20 && guard < 1000) begin
            deq_ready = ($urandom_range(0, 3) != 0);
            if (can_push() && $urandom_range(0, 2) != 0) begin
                push(pushed);
                pushed++;
            end
            tick();
            guard++;
        end
        check_eq("rand_push_budget", 64'(pushed), 64'd20);
        drain(200);
        check_eq("rand_popped", 64'(popped), 64'd20);
        check_eq("rand_ridx", async_ridx, to_gray(20));

        // source_valid drop with one entry held and three pending
        do_reset();
        mon_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push($urandom);
            tick();
        end
        repeat (6) tick();
        check_eq("sv_pre_valid", deq_valid, 1'b1);
        saved = deq_bits;
        mon_en = 1'b0;
        source_valid = 1'b0;
        async_widx = '0;
        tick();
        check_eq("sv_valid", deq_valid, 1'b0);
        check_eq("sv_ridx", async_ridx, '0);
        check_eq("sv_bits_held", deq_bits, saved);
        tick();
        check_eq("sv_mem_index", mem_index, '0);
        source_valid = 1'b1;
        model_clear();
        mon_en = 1'b1;
        repeat (10) tick();
        check_eq("sv_no_output", deq_valid, 1'b0);
        deq_ready = 1'b1;
        push(32'h1234_0000);
        tick();
        push(32'h1234_0001);
        drain(50);
        check_eq("sv_resume_ridx", async_ridx, 4'b0011);

        // Write pointer jumps two Gray bits at once
        do_reset();
        async_widx = 4'b0011;
        repeat (SYNC + 1) tick();
        check_eq("perr_set", ptr_err, PTR_CHK);
        repeat (5) tick();
        check_eq("perr_sticky", ptr_err, PTR_CHK);
        reset = 1'b1;
        async_widx = '0;
        tick();
        check_eq("perr_reset", ptr_err, 1'b0);
        reset = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
